// File: rtl/bram_bytelane_2p.sv
// True dual-port byte-lane block RAM with valid-tagged reads, same-port pass-through,
// deterministic cross-port write arbitration and a saturating collision monitor.
module bram_bytelane_2p #(
  parameter int addr_width = 12,
  parameter int byte_lanes = 4,
  parameter int out_reg    = 0,
  parameter int pass_thru  = 1,
  parameter int cross_fwd  = 0,
  parameter int prio_a     = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en_a,
  input  logic [byte_lanes-1:0]   we_a,
  input  logic [addr_width-1:0]   addr_a,
  input  logic [8*byte_lanes-1:0] wdata_a,
  output logic [8*byte_lanes-1:0] rdata_a,
  output logic                    rvalid_a,
  input  logic                    en_b,
  input  logic [byte_lanes-1:0]   we_b,
  input  logic [addr_width-1:0]   addr_b,
  input  logic [8*byte_lanes-1:0] wdata_b,
  output logic [8*byte_lanes-1:0] rdata_b,
  output logic                    rvalid_b,
  output logic                    collision,
  output logic [15:0]             collision_cnt
);

  localparam int dw    = 8 * byte_lanes;
  localparam int depth = 2 ** addr_width;

  logic [dw-1:0] mem [depth];

  logic                  same_addr_s;
  logic [byte_lanes-1:0] wa_s;
  logic [byte_lanes-1:0] wb_s;
  logic [byte_lanes-1:0] both_s;
  logic [byte_lanes-1:0] a_commit_s;
  logic [byte_lanes-1:0] b_commit_s;
  logic [dw-1:0]         mem_a_s;
  logic [dw-1:0]         mem_b_s;
  logic [dw-1:0]         rd_a_d;
  logic [dw-1:0]         rd_b_d;

  assign same_addr_s = en_a & en_b & (addr_a == addr_b);
  assign wa_s        = en_a ? we_a : {byte_lanes{1'b0}};
  assign wb_s        = en_b ? we_b : {byte_lanes{1'b0}};
  assign both_s      = same_addr_s ? (wa_s & wb_s) : {byte_lanes{1'b0}};
  // The losing port's byte on a contested lane is simply never committed.
  assign a_commit_s  = (prio_a != 0) ? wa_s : (wa_s & ~both_s);
  assign b_commit_s  = (prio_a != 0) ? (wb_s & ~both_s) : wb_s;
  assign mem_a_s     = mem[addr_a];
  assign mem_b_s     = mem[addr_b];

  // Per-lane read data: own pass-through first, then the other port's committed byte.
  always_comb begin
    rd_a_d = {dw{1'b0}};
    rd_b_d = {dw{1'b0}};
    for (int i = 0; i < byte_lanes; i++) begin
      rd_a_d[i*8 +: 8] = ((cross_fwd != 0) && same_addr_s && b_commit_s[i]) ? wdata_b[i*8 +: 8] :
                         ((pass_thru != 0) && wa_s[i])                     ? wdata_a[i*8 +: 8] :
                                                                              mem_a_s[i*8 +: 8];
      rd_b_d[i*8 +: 8] = ((cross_fwd != 0) && same_addr_s && a_commit_s[i]) ? wdata_a[i*8 +: 8] :
                         ((pass_thru != 0) && wb_s[i])                     ? wdata_b[i*8 +: 8] :
                                                                              mem_b_s[i*8 +: 8];
    end
  end

  // Storage is never reset; writes are only blocked while reset is held.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < byte_lanes; i++) begin
        if (a_commit_s[i]) mem[addr_a][i*8 +: 8] <= wdata_a[i*8 +: 8];
        if (b_commit_s[i]) mem[addr_b][i*8 +: 8] <= wdata_b[i*8 +: 8];
      end
    end
  end

  logic [dw-1:0] rd1_a_q;
  logic [dw-1:0] rd1_b_q;
  logic          rv1_a_q;
  logic          rv1_b_q;

  // First read stage: data only updates on an access so idle cycles hold it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd1_a_q <= {dw{1'b0}};
      rd1_b_q <= {dw{1'b0}};
      rv1_a_q <= 1'b0;
      rv1_b_q <= 1'b0;
    end else begin
      rv1_a_q <= en_a;
      rv1_b_q <= en_b;
      if (en_a) rd1_a_q <= rd_a_d;
      if (en_b) rd1_b_q <= rd_b_d;
    end
  end

  generate
    if (out_reg != 0) begin : g_oreg
      logic [dw-1:0] rd2_a_q;
      logic [dw-1:0] rd2_b_q;
      logic          rv2_a_q;
      logic          rv2_b_q;

      // Optional output stage, same hold-on-idle behaviour as the first stage.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rd2_a_q <= {dw{1'b0}};
          rd2_b_q <= {dw{1'b0}};
          rv2_a_q <= 1'b0;
          rv2_b_q <= 1'b0;
        end else begin
          rv2_a_q <= rv1_a_q;
          rv2_b_q <= rv1_b_q;
          if (rv1_a_q) rd2_a_q <= rd1_a_q;
          if (rv1_b_q) rd2_b_q <= rd1_b_q;
        end
      end

      assign rdata_a  = rd2_a_q;
      assign rdata_b  = rd2_b_q;
      assign rvalid_a = rv2_a_q;
      assign rvalid_b = rv2_b_q;
    end else begin : g_noreg
      assign rdata_a  = rd1_a_q;
      assign rdata_b  = rd1_b_q;
      assign rvalid_a = rv1_a_q;
      assign rvalid_b = rv1_b_q;
    end
  endgenerate

  logic        coll_d;
  logic        coll_q;
  logic [15:0] cnt_d;
  logic [15:0] cnt_q;

  assign coll_d = |both_s;

  // Saturating conflict counter, advancing together with the pulse.
  always_comb begin
    cnt_d = cnt_q;
    if (coll_d && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Collision pulse and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      coll_q <= 1'b0;
      cnt_q  <= 16'h0000;
    end else begin
      coll_q <= coll_d;
      cnt_q  <= cnt_d;
    end
  end

  assign collision     = coll_q;
  assign collision_cnt = cnt_q;

endmodule

// File: tb/tb_bram_bytelane_2p.sv
// Bench for bram_bytelane_2p: two parameter sets checked every cycle against a
// lane-level reference model, plus directed vectors with literal expectations.
module tb_bram_bytelane_2p;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        en_a [2];
  logic        en_b [2];
  logic [7:0]  we_a [2];
  logic [7:0]  we_b [2];
  logic [11:0] addr_a [2];
  logic [11:0] addr_b [2];
  logic [63:0] wdata_a [2];
  logic [63:0] wdata_b [2];

  logic [31:0] rda0, rdb0;
  logic [63:0] rda1, rdb1;
  logic        rva0, rvb0, rva1, rvb1, col0, col1;
  logic [15:0] cnt0, cnt1;

  int vecs = 0;
  int errs = 0;

  bram_bytelane_2p #(.addr_width(12), .byte_lanes(4), .out_reg(0), .pass_thru(1),
                     .cross_fwd(0), .prio_a(1)) u_d0 (
    .clk(clk), .rst_n(rst_n),
    .en_a(en_a[0]), .we_a(we_a[0][3:0]), .addr_a(addr_a[0]), .wdata_a(wdata_a[0][31:0]),
    .rdata_a(rda0), .rvalid_a(rva0),
    .en_b(en_b[0]), .we_b(we_b[0][3:0]), .addr_b(addr_b[0]), .wdata_b(wdata_b[0][31:0]),
    .rdata_b(rdb0), .rvalid_b(rvb0),
    .collision(col0), .collision_cnt(cnt0));

  bram_bytelane_2p #(.addr_width(6), .byte_lanes(8), .out_reg(1), .pass_thru(0),
                     .cross_fwd(1), .prio_a(0)) u_d1 (
    .clk(clk), .rst_n(rst_n),
    .en_a(en_a[1]), .we_a(we_a[1]), .addr_a(addr_a[1][5:0]), .wdata_a(wdata_a[1]),
    .rdata_a(rda1), .rvalid_a(rva1),
    .en_b(en_b[1]), .we_b(we_b[1]), .addr_b(addr_b[1][5:0]), .wdata_b(wdata_b[1]),
    .rdata_b(rdb1), .rvalid_b(rvb1),
    .collision(col1), .collision_cnt(cnt1));

  // Configuration of each instance as seen by the model.
  function automatic int nl(int k);  return (k == 0) ? 4 : 8; endfunction
  function automatic int lat(int k); return (k == 0) ? 1 : 2; endfunction
  function automatic bit pt(int k);  return (k == 0); endfunction
  function automatic bit cf(int k);  return (k != 0); endfunction
  function automatic bit pa(int k);  return (k == 0); endfunction
  function automatic bit wins(int k, int p); return (p == 0) ? pa(k) : !pa(k); endfunction

  // Model state: contents plus a per-byte "known" mask, expected outputs, middle stage.
  logic [63:0] mm [2][4096];
  logic [7:0]  kn [2][4096];
  logic [63:0] ex_rd [2][2];
  logic [7:0]  ex_kn [2][2];
  logic        ex_v [2][2];
  logic [63:0] s1_rd [2][2];
  logic [7:0]  s1_kn [2][2];
  logic        s1_v [2][2];
  logic        ex_col [2];
  int          ex_cnt [2];

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic model_reset(int k);
    for (int p = 0; p < 2; p++) begin
      ex_v[k][p] = 1'b0; ex_rd[k][p] = 64'd0; ex_kn[k][p] = 8'hFF;
      s1_v[k][p] = 1'b0; s1_rd[k][p] = 64'd0; s1_kn[k][p] = 8'hFF;
    end
    ex_col[k] = 1'b0;
    ex_cnt[k] = 0;
  endtask

  task automatic model_step(int k);
    int          ad [2];
    logic        en [2];
    logic [7:0]  we [2];
    logic [63:0] wd [2];
    logic [63:0] r [2];
    logic [7:0]  rk [2];
    logic        same;
    logic        conflict;
    int          amask;
    logic [7:0]  lm;
    amask = (k == 0) ? 4095 : 63;
    lm    = (k == 0) ? 8'h0F : 8'hFF;
    if (!rst_n) begin
      model_reset(k);
    end else begin
      en[0] = en_a[k];  en[1] = en_b[k];
      we[0] = we_a[k] & lm; we[1] = we_b[k] & lm;
      wd[0] = wdata_a[k]; wd[1] = wdata_b[k];
      ad[0] = int'(addr_a[k]) & amask; ad[1] = int'(addr_b[k]) & amask;
      same  = en[0] && en[1] && (ad[0] == ad[1]);
      for (int p = 0; p < 2; p++) begin
        r[p] = 64'd0; rk[p] = 8'h00;
        if (en[p]) begin
          r[p] = mm[k][ad[p]]; rk[p] = kn[k][ad[p]];
          for (int i = 0; i < nl(k); i++) begin
            if (pt(k) && we[p][i]) begin
              r[p][i*8 +: 8] = wd[p][i*8 +: 8]; rk[p][i] = 1'b1;
            end
            if (cf(k) && same && we[1-p][i] && (!we[p][i] || wins(k, 1-p))) begin
              r[p][i*8 +: 8] = wd[1-p][i*8 +: 8]; rk[p][i] = 1'b1;
            end
          end
        end
      end
      for (int i = 0; i < nl(k); i++)
        for (int p = 0; p < 2; p++)
          if (en[p] && we[p][i] && !(same && we[1-p][i] && wins(k, 1-p))) begin
            mm[k][ad[p]][i*8 +: 8] = wd[p][i*8 +: 8];
            kn[k][ad[p]][i] = 1'b1;
          end
      conflict = same && ((we[0] & we[1]) != 8'h00);
      for (int p = 0; p < 2; p++) begin
        if (lat(k) == 1) begin
          ex_v[k][p] = en[p];
          if (en[p]) begin ex_rd[k][p] = r[p]; ex_kn[k][p] = rk[p]; end
        end else begin
          ex_v[k][p] = s1_v[k][p];
          if (s1_v[k][p]) begin ex_rd[k][p] = s1_rd[k][p]; ex_kn[k][p] = s1_kn[k][p]; end
          s1_v[k][p] = en[p];
          if (en[p]) begin s1_rd[k][p] = r[p]; s1_kn[k][p] = rk[p]; end
        end
      end
      ex_col[k] = conflict;
      if (conflict && ex_cnt[k] < 65535) ex_cnt[k]++;
    end
  endtask

  function automatic logic [63:0] rd_out(int k, int p);
    if (k == 0) return (p == 0) ? {32'd0, rda0} : {32'd0, rdb0};
    else        return (p == 0) ? rda1 : rdb1;
  endfunction

  function automatic logic rv_out(int k, int p);
    if (k == 0) return (p == 0) ? rva0 : rvb0;
    else        return (p == 0) ? rva1 : rvb1;
  endfunction

  task automatic compare(int k);
    logic [63:0] m;
    if (!rst_n) model_reset(k);
    for (int p = 0; p < 2; p++) begin
      m = 64'd0;
      for (int i = 0; i < nl(k); i++) if (ex_kn[k][p][i]) m[i*8 +: 8] = 8'hFF;
      chk($sformatf("rvalid[%0d][%0d]", k, p), {63'd0, rv_out(k, p)}, {63'd0, ex_v[k][p]});
      chk($sformatf("rdata[%0d][%0d]", k, p), rd_out(k, p) & m, ex_rd[k][p] & m);
    end
    chk($sformatf("collision[%0d]", k), {63'd0, (k == 0) ? col0 : col1}, {63'd0, ex_col[k]});
    chk($sformatf("collision_cnt[%0d]", k), {48'd0, (k == 0) ? cnt0 : cnt1}, 64'(ex_cnt[k]));
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      for (int a = 0; a < 4096; a++) begin mm[k][a] = 64'd0; kn[k][a] = 8'h00; end
      model_reset(k);
    end
    forever begin
      @(posedge clk);
      model_step(0);
      model_step(1);
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      #1;
      compare(0);
      compare(1);
    end
  end

  task automatic drv(int k, logic ea, logic [7:0] wa, logic [11:0] aa, logic [63:0] da,
                     logic eb, logic [7:0] wb, logic [11:0] ab, logic [63:0] db);
    en_a[k] = ea; we_a[k] = wa; addr_a[k] = aa; wdata_a[k] = da;
    en_b[k] = eb; we_b[k] = wb; addr_b[k] = ab; wdata_b[k] = db;
  endtask

  task automatic idle(int k);
    drv(k, 1'b0, 8'h00, 12'h000, 64'd0, 1'b0, 8'h00, 12'h000, 64'd0);
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst_n = 1'b0;
    idle(0);
    idle(1);
    repeat (3) cyc();
    chk("reset rdata_a", {32'd0, rda0}, 64'd0);
    chk("reset rvalid_a", {63'd0, rva0}, 64'd0);
    chk("reset collision_cnt", {48'd0, cnt0}, 64'd0);
    rst_n = 1'b1;

    // Basic write on A, read on B, then hold on idle.
    drv(0, 1'b1, 8'h0F, 12'h010, 64'hDEADBEEF, 1'b0, 8'h00, 12'h000, 64'd0);
    cyc();
    chk("write return a", {32'd0, rda0}, 64'hDEADBEEF);
    drv(0, 1'b0, 8'h00, 12'h000, 64'd0, 1'b1, 8'h00, 12'h010, 64'd0);
    cyc();
    chk("read b valid", {63'd0, rvb0}, 64'd1);
    chk("read b data", {32'd0, rdb0}, 64'hDEADBEEF);
    chk("idle a no valid", {63'd0, rva0}, 64'd0);
    idle(0);
    cyc();
    chk("idle b no valid", {63'd0, rvb0}, 64'd0);
    chk("idle b hold", {32'd0, rdb0}, 64'hDEADBEEF);

    // Byte lanes with pass-through on instance 0.
    drv(0, 1'b1, 8'h0F, 12'h020, 64'h11223344, 1'b0, 8'h00, 12'h000, 64'd0);
    cyc();
    drv(0, 1'b1, 8'h05, 12'h020, 64'hAABBCCDD, 1'b0, 8'h00, 12'h000, 64'd0);
    cyc();
    chk("pass_thru=1 return", {32'd0, rda0}, 64'h11BB33DD);
    drv(0, 1'b1, 8'h00, 12'h020, 64'd0, 1'b0, 8'h00, 12'h000, 64'd0);
    cyc();
    chk("lane merge read", {32'd0, rda0}, 64'h11BB33DD);
    idle(0);

    // Byte lanes without pass-through, latency 2, on instance 1.
    drv(1, 1'b1, 8'hFF, 12'h020, 64'h11223344, 1'b0, 8'h00, 12'h000, 64'd0);
    cyc();
    drv(1, 1'b1, 8'h05, 12'h020, 64'hAABBCCDD, 1'b0, 8'h00, 12'h000, 64'd0);
    cyc();
    drv(1, 1'b1, 8'h00, 12'h020, 64'd0, 1'b0, 8'h00, 12'h000, 64'd0);
    cyc();
    chk("pass_thru=0 return", rda1, 64'h11223344);
    idle(1);
    cyc();
    chk("lane merge read L2", rda1, 64'h11BB33DD);
    cyc();
    chk("L2 idle no valid", {63'd0, rva1}, 64'd0);

    // Collision, A priority, no cross forwarding.
    drv(0, 1'b1, 8'h0F, 12'h030, 64'd0, 1'b0, 8'h00, 12'h000, 64'd0);
    cyc();
    drv(0, 1'b1, 8'h03, 12'h030, 64'h0000A1A2, 1'b1, 8'h06, 12'h030, 64'h00B2B300);
    cyc();
    chk("collision pulse", {63'd0, col0}, 64'd1);
    chk("collision_cnt 1", {48'd0, cnt0}, 64'd1);
    chk("collide return a", {32'd0, rda0}, 64'h0000A1A2);
    chk("collide return b", {32'd0, rdb0}, 64'h00B2B300);
    drv(0, 1'b1, 8'h00, 12'h030, 64'd0, 1'b0, 8'h00, 12'h000, 64'd0);
    cyc();
    chk("collision single cycle", {63'd0, col0}, 64'd0);
    chk("prio_a=1 merge", {32'd0, rda0}, 64'h00B2A1A2);
    idle(0);

    // Collision, B priority, cross forwarding, on instance 1.
    drv(1, 1'b1, 8'hFF, 12'h030, 64'd0, 1'b0, 8'h00, 12'h000, 64'd0);
    cyc();
    drv(1, 1'b1, 8'h03, 12'h030, 64'h0000A1A2, 1'b1, 8'h06, 12'h030, 64'h00B2B300);
    cyc();
    chk("collision pulse L2", {63'd0, col1}, 64'd1);
    chk("collision_cnt L2", {48'd0, cnt1}, 64'd1);
    drv(1, 1'b1, 8'h00, 12'h030, 64'd0, 1'b0, 8'h00, 12'h000, 64'd0);
    cyc();
    chk("cross_fwd return a", rda1, 64'h00B2B300);
    idle(1);
    cyc();
    chk("prio_a=0 merge", rda1, 64'h00B2B3A2);

    // Back-to-back pipelined reads on instance 1.
    for (int j = 0; j < 8; j++) begin
      drv(1, 1'b1, 8'hFF, 12'(8 + j), 64'hA5A5000000000000 + 64'(j), 1'b0, 8'h00, 12'h000, 64'd0);
      cyc();
    end
    idle(1);
    cyc();
    cyc();
    for (int j = 0; j < 8; j++) begin
      drv(1, 1'b1, 8'h00, 12'(8 + j), 64'd0, 1'b0, 8'h00, 12'h000, 64'd0);
      cyc();
      if (j == 0) begin
        chk("pipe first not yet", {63'd0, rva1}, 64'd0);
      end else begin
        chk("pipe valid", {63'd0, rva1}, 64'd1);
        chk("pipe data", rda1, 64'hA5A5000000000000 + 64'(j - 1));
      end
    end
    idle(1);
    cyc();
    chk("pipe last valid", {63'd0, rva1}, 64'd1);
    chk("pipe last data", rda1, 64'hA5A5000000000007);
    cyc();
    chk("pipe end", {63'd0, rva1}, 64'd0);

    // Reset in the middle of a read stream, with a write attempted under reset.
    drv(0, 1'b1, 8'h00, 12'h010, 64'd0, 1'b1, 8'h00, 12'h020, 64'd0);
    cyc();
    cyc();
    #3;
    rst_n = 1'b0;
    drv(0, 1'b1, 8'h0F, 12'h010, 64'h12345678, 1'b0, 8'h00, 12'h000, 64'd0);
    #2;
    chk("async reset rdata_a", {32'd0, rda0}, 64'd0);
    chk("async reset rvalid_a", {63'd0, rva0}, 64'd0);
    chk("async reset rvalid_b", {63'd0, rvb0}, 64'd0);
    chk("async reset cnt", {48'd0, cnt0}, 64'd0);
    repeat (3) cyc();
    rst_n = 1'b1;
    idle(0);
    cyc();
    chk("no stale valid a", {63'd0, rva0}, 64'd0);
    chk("no stale valid b", {63'd0, rvb0}, 64'd0);
    drv(0, 1'b1, 8'h00, 12'h010, 64'd0, 1'b0, 8'h00, 12'h000, 64'd0);
    cyc();
    chk("retained after reset", {32'd0, rda0}, 64'hDEADBEEF);
    idle(0);
    cyc();

    // Saturation of the conflict counter.
    drv(0, 1'b1, 8'h01, 12'h100, 64'h000000AA, 1'b1, 8'h01, 12'h100, 64'h000000BB);
    repeat (65537) cyc();
    chk("cnt saturated", {48'd0, cnt0}, 64'h000000000000FFFF);
    chk("collision held", {63'd0, col0}, 64'd1);
    idle(0);
    cyc();
    chk("collision drop", {63'd0, col0}, 64'd0);
    chk("cnt stays", {48'd0, cnt0}, 64'h000000000000FFFF);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/bram_bytelane_2p.md
Name: bram_bytelane_2p

Overview:
Parametrised true dual-port, byte-addressable block RAM with a configurable number of byte lanes and an optional output pipeline register. It adds valid-tagged read returns, same-port read-during-write pass-through, and deterministic cross-port collision resolution with a collision monitor. It sits under the CPU and video and DMA memory paths as the general successor to the fixed 4-lane 32-bit BRAM. It runs on a single clock.

Parameters:
addr_width, 12, word address bits; depth = 2**addr_width words
byte_lanes, 4, bytes per word; word width dw = 8*byte_lanes; lane i = bits i*8+7:i*8
out_reg, 0, 0 = read latency 1; 1 = extra output register, read latency 2
pass_thru, 1, same-port read-during-write returns the new byte on written lanes (1) or the old byte (0)
cross_fwd, 0, cross-port read of an address the other port writes in the same cycle returns the new bytes (1) or the old data (0)
prio_a, 1, same-cycle same-address same-lane write conflict: port A wins (1) or port B wins (0)

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous, active-low reset
en_a  in  1  port A access enable
we_a  in  byte_lanes  port A per-lane write enable, qualified by en_a
addr_a  in  addr_width  port A word address
wdata_a  in  dw  port A write data
rdata_a  out  dw  port A read data
rvalid_a  out  1  port A read data valid, 1-cycle pulse per access
en_b, we_b, addr_b, wdata_b, rdata_b, rvalid_b: same as port A, for port B
collision  out  1  registered pulse marking a write-write lane conflict
collision_cnt  out  16  saturating count of conflict cycles

Behaviour:
- Access: a port performs an access at a rising edge where en_x=1 and rst_n=1.
  - Every access produces a read, including accesses where we_x≠0.
  - Lane i is written iff we_x[i]=1. Lanes with we_x[i]=0 are unchanged.
- Latency:
  - rdata_x and rvalid_x appear L cycles after the access edge; L = 1 + out_reg.
  - The path is fully pipelined: back-to-back accesses on consecutive cycles give back-to-back rvalid.
- Idle port: when en_x=0, no rvalid is generated. rdata_x holds its last value, and rvalid_x=0 in the corresponding return cycle.
- Same-port read-during-write:
  - pass_thru=1: each written lane returns wdata_x for that lane; unwritten lanes return the stored byte.
  - pass_thru=0: all lanes return the pre-write contents.
- Cross-port, same cycle, addr_a==addr_b, both enabled:
  - Write-write on lane i (we_a[i] and we_b[i] both 1): the winner is A if prio_a=1, else B. The loser's byte is discarded.
  - Disjoint lanes from the two ports both commit.
  - Read vs the other port's write: cross_fwd=1 returns the committed new byte on lanes the other port wrote; cross_fwd=0 returns old data.
  - A port's own pass_thru applies first; the other port's write then overrides per lane, according to priority, when cross_fwd=1.
- collision:
  - Asserted for 1 cycle, on the edge after a cycle with en_a & en_b & (addr_a==addr_b) & |(we_a & we_b).
  - Consecutive conflicting cycles give consecutive pulses.
- collision_cnt: increments by 1 on each collision pulse and saturates at 16'hFFFF.
- Reset (rst_n=0, asynchronous):
  - rdata_a and rdata_b = 0; rvalid_a and rvalid_b = 0; pipeline registers cleared; collision = 0; collision_cnt = 0.
  - Memory contents are retained, not cleared.
  - Writes are suppressed while rst_n=0.
  - Reads in flight when reset asserts are dropped: no rvalid after release for accesses issued before or during reset.
- Reset release: the first edge with rst_n=1 is a normal access edge.
- Address wrap: none. Addresses are exactly addr_width bits and all values are valid.

Test Plan:
- Basic, out_reg=0: A writes addr 0x010, we=4'hF, data 0xDEADBEEF; next cycle B reads 0x010 -> rdata_b=0xDEADBEEF with rvalid_b=1 exactly 1 cycle after the read edge.
- Byte lanes: write 0x11223344 to 0x020; then A writes we=4'b0101, data 0xAABBCCDD -> a later read returns 0x11BB33DD. Same-port pass_thru=1 returns 0x11BB33DD in the write's own return; pass_thru=0 returns 0x11223344.
- Collision, prio_a=1, cross_fwd=0: old 0x00000000 at 0x030. A writes we=4'b0011, 0x0000A1A2; B writes we=4'b0110, 0x00B2B300, same cycle -> memory 0x00B2A1A2; collision=1 for 1 cycle; collision_cnt=1. Same test with prio_a=0 -> 0x00B2B3A2.
- Pipeline, out_reg=1, byte_lanes=8: A reads 8 consecutive addresses back-to-back -> 8 consecutive rvalid_a pulses starting 2 cycles after the first access, data in order.
- Reset mid-operation: issue reads on cycles 0–1; assert rst_n=0 at cycle 1.5 for 3 cycles -> rdata=0 and rvalid=0 immediately, no rvalid after release, memory data preserved on a subsequent read. A write attempted during reset leaves the target address unchanged.
- Saturation: force 65537 conflicting cycles -> collision_cnt stays at 16'hFFFF.
